// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_btb
// Description : Branch target buffer with selectable direction predictor
//               (static not-taken, bimodal 2-bit counters, or gshare).
//               Zero-latency lookup for IF; resolved-outcome update from EX.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16,
    parameter int MODE    = 1,
    parameter int GHR_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic [GHR_W-1:0] upd_ghr
);

    localparam int         IDX_W       = $clog2(ENTRIES);
    localparam int         TAG_W       = PC_W - IDX_W - 2;
    localparam logic [1:0] C_CTR_RESET = 2'b01;
    localparam logic [1:0] C_CTR_ALLOC = 2'b10;

    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_d   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [1:0]       ctr_d   [ENTRIES];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    // Low until the first clock edge after reset release; the update seen
    // on that edge is discarded.
    logic             armed_q;
    logic             armed_d;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] pred_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             pred_hit;
    logic             upd_hit;
    logic             upd_en;
    logic [1:0]       unused_upd_pc_lsbs;

    assign unused_upd_pc_lsbs = upd_pc[1:0];
    assign pred_tag           = pred_pc[PC_W-1:IDX_W+2];
    assign upd_tag            = upd_pc[PC_W-1:IDX_W+2];

    // Table index: word-aligned PC bits, hashed with history in gshare mode
    always_comb begin
        pred_idx = pred_pc[IDX_W+1:2];
        upd_idx  = upd_pc[IDX_W+1:2];
        if (MODE == 2) begin
            pred_idx = pred_idx ^ IDX_W'(ghr_q);
            upd_idx  = upd_idx ^ IDX_W'(upd_ghr);
        end
    end

    // Combinational lookup; reads pre-update state so same-cycle writes are not forwarded
    always_comb begin
        pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken  = (MODE != 0) && pred_hit && ctr_q[pred_idx][1];
        pred_target = pred_taken ? tgt_q[pred_idx] : pred_pc + PC_W'(4);
        pred_ghr    = (MODE == 2) ? ghr_q : '0;
    end

    // Next-state for table, history and arm flag; everything gated by upd_en
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        ghr_d   = ghr_q;
        armed_d = 1'b1;
        upd_en  = upd_valid && armed_q && (MODE != 0);
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
                    tgt_d[upd_idx] = upd_target;
                end else begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = upd_target;
                ctr_d[upd_idx]   = C_CTR_ALLOC;
            end
            if (MODE == 2) begin
                ghr_d = GHR_W'({ghr_q, upd_taken});
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= C_CTR_RESET;
            end
            ghr_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
            ghr_q   <= ghr_d;
            armed_q <= armed_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_btb
// Description : Directed self-checking bench; one predictor per mode shares
//               a common stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

    logic        clk;
    logic        reset;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [3:0]  upd_ghr;

    logic        taken0, taken1, taken2;
    logic [31:0] tgt0, tgt1, tgt2;
    logic [3:0]  ghr0, ghr1, ghr2;

    int n_vec;
    int n_err;

    branch_predictor_btb #(.PC_W(32), .ENTRIES(16), .MODE(0), .GHR_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(taken0),
        .pred_target(tgt0), .pred_ghr(ghr0), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr)
    );
    branch_predictor_btb #(.PC_W(32), .ENTRIES(16), .MODE(1), .GHR_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(taken1),
        .pred_target(tgt1), .pred_ghr(ghr1), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr)
    );
    branch_predictor_btb #(.PC_W(32), .ENTRIES(16), .MODE(2), .GHR_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(taken2),
        .pred_target(tgt2), .pred_ghr(ghr2), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        pred_pc = pc;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [3:0] gh);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_ghr    = gh;
        tick();
        upd_valid  = 1'b0;
        upd_pc     = 'x;
        upd_taken  = 1'bx;
        upd_target = 'x;
        upd_ghr    = '0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b0;
        pred_pc    = 32'h40;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        upd_ghr    = '0;
        tick();
        tick();

        // Reset state while held
        look(32'h40);
        check("rst_taken", {31'b0, taken1}, 32'd0);
        check("rst_target", tgt1, 32'h44);
        check("rst_ghr", {28'b0, ghr2}, 32'd0);

        // Release reset with an update in the same cycle: must be dropped
        reset = 1'b1;
        upd(32'h40, 1'b1, 32'h10, 4'h0);
        look(32'h40);
        check("drop_at_release_taken", {31'b0, taken1}, 32'd0);
        check("drop_at_release_target", tgt1, 32'h44);
        check("drop_at_release_ghr", {28'b0, ghr2}, 32'd0);
        look(32'hFFFF_FFFC);
        check("wrap_target", tgt1, 32'h0000_0000);

        // Allocate, then weaken
        upd(32'h40, 1'b1, 32'h10, 4'h0);
        look(32'h40);
        check("alloc_taken", {31'b0, taken1}, 32'd1);
        check("alloc_target", tgt1, 32'h10);
        upd(32'h40, 1'b0, 32'h0, 4'h0);
        look(32'h40);
        check("weak_nt_taken", {31'b0, taken1}, 32'd0);
        check("weak_nt_target", tgt1, 32'h44);

        // Saturation high: ctr 1 -> 3 (saturated), one NT -> 2
        for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h10, 4'h0);
        upd(32'h40, 1'b0, 32'h0, 4'h0);
        look(32'h40);
        check("sat_hi_taken", {31'b0, taken1}, 32'd1);
        // Saturation low: 2 -> 0 (saturated), one T -> 1
        for (int i = 0; i < 3; i++) upd(32'h40, 1'b0, 32'h0, 4'h0);
        upd(32'h40, 1'b1, 32'h10, 4'h0);
        look(32'h40);
        check("sat_lo_taken", {31'b0, taken1}, 32'd0);

        // Aliasing at index 0
        upd(32'h40, 1'b1, 32'h10, 4'h0);
        look(32'h40);
        check("alias_pre_taken", {31'b0, taken1}, 32'd1);
        look(32'h80);
        check("alias_miss_taken", {31'b0, taken1}, 32'd0);
        check("alias_miss_target", tgt1, 32'h84);
        upd(32'h80, 1'b1, 32'h200, 4'h0);
        look(32'h80);
        check("alias_new_target", tgt1, 32'h200);
        look(32'h40);
        check("alias_evicted_taken", {31'b0, taken1}, 32'd0);
        check("alias_evicted_target", tgt1, 32'h44);

        // Same-cycle update and lookup on fresh entry (index 1)
        pred_pc    = 32'h44;
        upd_valid  = 1'b1;
        upd_pc     = 32'h44;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        upd_ghr    = 4'h0;
        #1;
        check("rbw_old_taken", {31'b0, taken1}, 32'd0);
        check("rbw_old_target", tgt1, 32'h48);
        tick();
        upd_valid = 1'b0;
        #1;
        check("rbw_new_taken", {31'b0, taken1}, 32'd1);
        check("rbw_new_target", tgt1, 32'h300);

        // Gshare history fills with four taken outcomes
        for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h500, 4'h0);
        check("ghr_full", {28'b0, ghr2}, 32'hF);
        check("ghr_mode1_zero", {28'b0, ghr1}, 32'd0);
        look(32'h100);
        check("mode1_hit_100", {31'b0, taken1}, 32'd1);
        check("mode0_never_taken", {31'b0, taken0}, 32'd0);
        check("mode0_target", tgt0, 32'h104);
        look(32'h80);
        check("mode0_never_taken_80", {31'b0, taken0}, 32'd0);

        // Asynchronous reset pulse mid-cycle, no clock edge
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_ghr", {28'b0, ghr2}, 32'd0);
        check("async_m1_taken", {31'b0, taken1}, 32'd0);
        check("async_m1_target", tgt1, 32'h84);
        pred_pc = 32'h100;
        #1;
        check("async_m1_miss_100", {31'b0, taken1}, 32'd0);
        check("async_m1_target_100", tgt1, 32'h104);
        reset = 1'b1;
        tick();
        tick();

        // Gshare hashing: after one taken update GHR=0001, so 0x40 maps to index 1 (empty)
        upd(32'h40, 1'b1, 32'h10, 4'h0);
        look(32'h40);
        check("gshare_ghr_one", {28'b0, ghr2}, 32'h1);
        check("gshare_hash_miss", {31'b0, taken2}, 32'd0);
        check("bimodal_same_hit", {31'b0, taken1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
